// File: rtl/vspi_pkg.sv
// Shared vSPI memory definitions: RAM geometry, read-owner tags and arbiter states.
package vspi_pkg;

    localparam int VSPI_MEM_ADDR_W = 12;
    localparam int VSPI_MEM_DATA_W = 8;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_SPI,
        OWN_USR
    } owner_e;

    typedef enum logic {
        UNLOCKED,
        LOCKED
    } arb_state_e;

endpackage

// File: rtl/vspi_mem_arb.sv
// Arbiter for the single-port vSPI RAM: SPI side has priority and may lock the RAM for a stream;
// a starvation guard forces a user grant while unlocked.
module vspi_mem_arb
    import vspi_pkg::*;
#(
    parameter int          ADDR_W     = VSPI_MEM_ADDR_W,
    parameter int          DATA_W     = VSPI_MEM_DATA_W,
    parameter int unsigned STARVE_LIM = 8
) (
    input  logic              SysClk,
    input  logic              Reset,

    input  logic              spi_req,
    input  logic              spi_we,
    input  logic [ADDR_W-1:0] spi_addr,
    input  logic [DATA_W-1:0] spi_wdata,
    input  logic              spi_lock,
    output logic              spi_gnt,
    output logic [DATA_W-1:0] spi_rdata,
    output logic              spi_rvalid,

    input  logic              usr_req,
    input  logic              usr_we,
    input  logic [ADDR_W-1:0] usr_addr,
    input  logic [DATA_W-1:0] usr_wdata,
    output logic              usr_gnt,
    output logic [DATA_W-1:0] usr_rdata,
    output logic              usr_rvalid,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              locked
);

    localparam int          CNT_W   = $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(STARVE_LIM);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic [DATA_W-1:0] spi_rdata_q, spi_rdata_d;
    logic [DATA_W-1:0] usr_rdata_q, usr_rdata_d;

    logic force_usr;
    logic spi_acc;
    logic usr_acc;

    always_ff @(posedge SysClk or posedge Reset) begin
        if (Reset) begin
            state_q     <= UNLOCKED;
            owner_q     <= OWN_NONE;
            starve_q    <= '0;
            spi_rdata_q <= '0;
            usr_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            spi_rdata_q <= spi_rdata_d;
            usr_rdata_q <= usr_rdata_d;
        end
    end

    // Grant selection; everything is held off while Reset is asserted.
    always_comb begin
        spi_gnt   = 1'b0;
        usr_gnt   = 1'b0;
        force_usr = (state_q == UNLOCKED) && usr_req && (starve_q == CNT_LIM);
        if (!Reset) begin
            if (state_q == LOCKED) begin
                spi_gnt = 1'b1;
            end else if (force_usr) begin
                usr_gnt = 1'b1;
            end else begin
                spi_gnt = spi_req;
                usr_gnt = usr_req && !spi_req;
            end
        end
        spi_acc = spi_req && spi_gnt;
        usr_acc = usr_req && usr_gnt;
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (spi_acc) begin
            mem_en    = 1'b1;
            mem_we    = spi_we;
            mem_addr  = spi_addr;
            mem_wdata = spi_wdata;
        end else if (usr_acc) begin
            mem_en    = 1'b1;
            mem_we    = usr_we;
            mem_addr  = usr_addr;
            mem_wdata = usr_wdata;
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (spi_acc && !spi_we) begin
            owner_d = OWN_SPI;
        end else if (usr_acc && !usr_we) begin
            owner_d = OWN_USR;
        end
    end

    // Unlock waits until no SPI read is about to return, so its rvalid still lands under lock.
    always_comb begin
        state_d = state_q;
        case (state_q)
            UNLOCKED: if (spi_lock) state_d = LOCKED;
            LOCKED:   if (!spi_lock && !(spi_acc && !spi_we)) state_d = UNLOCKED;
            default:  state_d = UNLOCKED;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (state_q == UNLOCKED) begin
            if (!usr_req || usr_gnt) begin
                starve_d = '0;
            end else if (starve_q != CNT_LIM) begin
                starve_d = starve_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        spi_rvalid  = (owner_q == OWN_SPI);
        usr_rvalid  = (owner_q == OWN_USR);
        spi_rdata_d = spi_rvalid ? mem_rdata : spi_rdata_q;
        usr_rdata_d = usr_rvalid ? mem_rdata : usr_rdata_q;
        spi_rdata   = spi_rdata_d;
        usr_rdata   = usr_rdata_d;
        locked      = (state_q == LOCKED);
    end

endmodule

// File: tb/tb_vspi_mem_arb.sv
// Directed bench for vspi_mem_arb with a behavioural 4096x8 synchronous RAM.
module tb_vspi_mem_arb;

    logic        SysClk = 1'b0;
    logic        Reset;
    logic        spi_req, spi_we, spi_lock;
    logic [11:0] spi_addr;
    logic [7:0]  spi_wdata;
    logic        spi_gnt, spi_rvalid;
    logic [7:0]  spi_rdata;
    logic        usr_req, usr_we;
    logic [11:0] usr_addr;
    logic [7:0]  usr_wdata;
    logic        usr_gnt, usr_rvalid;
    logic [7:0]  usr_rdata;
    logic        mem_en, mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        locked;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [7:0] ram [4096];

    always #5 SysClk = ~SysClk;

    always @(posedge SysClk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    vspi_mem_arb #(
        .ADDR_W    (12),
        .DATA_W    (8),
        .STARVE_LIM(8)
    ) dut (
        .SysClk    (SysClk),
        .Reset     (Reset),
        .spi_req   (spi_req),
        .spi_we    (spi_we),
        .spi_addr  (spi_addr),
        .spi_wdata (spi_wdata),
        .spi_lock  (spi_lock),
        .spi_gnt   (spi_gnt),
        .spi_rdata (spi_rdata),
        .spi_rvalid(spi_rvalid),
        .usr_req   (usr_req),
        .usr_we    (usr_we),
        .usr_addr  (usr_addr),
        .usr_wdata (usr_wdata),
        .usr_gnt   (usr_gnt),
        .usr_rdata (usr_rdata),
        .usr_rvalid(usr_rvalid),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .locked    (locked)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic spi(input logic req, input logic we, input logic [11:0] addr, input logic [7:0] wd);
        spi_req   = req;
        spi_we    = we;
        spi_addr  = addr;
        spi_wdata = wd;
    endtask

    task automatic usr(input logic req, input logic we, input logic [11:0] addr, input logic [7:0] wd);
        usr_req   = req;
        usr_we    = we;
        usr_addr  = addr;
        usr_wdata = wd;
    endtask

    initial begin
        Reset     = 1'b1;
        spi_lock  = 1'b0;
        mem_rdata = '0;
        spi(0, 0, '0, '0);
        usr(0, 0, '0, '0);

        // Reset: outputs quiet even with requests pending
        repeat (2) @(negedge SysClk);
        spi_req = 1'b1;
        usr_req = 1'b1;
        #1;
        chk("rst_gnt",    {30'd0, spi_gnt, usr_gnt}, 32'h0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_locked", locked, 0);
        chk("rst_rvalid", {30'd0, spi_rvalid, usr_rvalid}, 32'h0);
        spi_req = 1'b0;
        usr_req = 1'b0;
        @(negedge SysClk);
        Reset = 1'b0;

        // User-only write then read
        @(negedge SysClk);
        usr(1, 1, 12'h123, 8'hA5);
        #1;
        chk("u_wr_gnt",   {30'd0, spi_gnt, usr_gnt}, 32'h1);
        chk("u_wr_mem",   {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 12'h123, 8'hA5});
        @(negedge SysClk);
        usr(1, 0, 12'h123, 8'h00);
        #1;
        chk("u_rd_gnt",   usr_gnt, 1);
        chk("u_rd_mem",   {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 12'h123});
        @(negedge SysClk);
        usr(0, 0, '0, '0);
        #1;
        chk("u_rvalid",   usr_rvalid, 1);
        chk("u_rdata",    usr_rdata, 8'hA5);
        chk("u_spi_rv",   spi_rvalid, 0);
        chk("idle_mem",   {mem_en, mem_we, mem_addr, mem_wdata}, '0);
        @(negedge SysClk);
        #1;
        chk("u_rv_pulse", usr_rvalid, 0);
        chk("u_rd_hold",  usr_rdata, 8'hA5);

        // SPI-only write then read
        @(negedge SysClk);
        spi(1, 1, 12'hFFF, 8'h3C);
        #1;
        chk("s_wr_gnt",   {30'd0, spi_gnt, usr_gnt}, 32'h2);
        @(negedge SysClk);
        spi(1, 0, 12'hFFF, 8'h00);
        #1;
        chk("s_rd_mem",   {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 12'hFFF});
        @(negedge SysClk);
        spi(0, 0, '0, '0);
        #1;
        chk("s_rvalid",   {30'd0, spi_rvalid, usr_rvalid}, 32'h2);
        chk("s_rdata",    spi_rdata, 8'h3C);
        chk("s_u_hold",   usr_rdata, 8'hA5);

        // Continuous contention: user forced in every 9th cycle
        for (int i = 0; i < 18; i++) begin
            @(negedge SysClk);
            spi(1, 1, 12'h200, 8'(i));
            usr(1, 1, 12'h201, 8'(i));
            #1;
            chk($sformatf("cont_%0d", i), {30'd0, spi_gnt, usr_gnt},
                ((i % 9) == 8) ? 32'h1 : 32'h2);
        end
        @(negedge SysClk);
        spi(0, 0, '0, '0);
        usr(0, 0, '0, '0);

        // Lock holds off the user through spi_req gaps
        @(negedge SysClk);
        spi_lock = 1'b1;
        #1;
        chk("lk_pre",     locked, 0);
        @(negedge SysClk);
        #1;
        chk("lk_set",     locked, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge SysClk);
            usr(1, 0, 12'h123, 8'h00);
            spi(1'(i % 2), 1, 12'h300, 8'(i));
            #1;
            chk($sformatf("lk_%0d", i), {29'd0, locked, spi_gnt, usr_gnt}, 32'h6);
        end
        @(negedge SysClk);
        spi_lock = 1'b0;
        spi_req  = 1'b0;
        #1;
        chk("unlk_cyc0",  {30'd0, locked, usr_gnt}, 32'h2);
        @(negedge SysClk);
        #1;
        chk("unlk_cyc1",  {30'd0, locked, usr_gnt}, 32'h1);
        @(negedge SysClk);
        usr(0, 0, '0, '0);
        #1;
        chk("unlk_rdata", {23'd0, usr_rvalid, usr_rdata}, {23'd0, 1'b1, 8'hA5});

        // Cross-side ordering: SPI write then user read next cycle
        @(negedge SysClk);
        spi(1, 1, 12'h010, 8'h5A);
        #1;
        chk("ord_wr",     spi_gnt, 1);
        @(negedge SysClk);
        spi(0, 0, '0, '0);
        usr(1, 0, 12'h010, 8'h00);
        #1;
        chk("ord_rd",     usr_gnt, 1);
        @(negedge SysClk);
        usr(0, 0, '0, '0);
        #1;
        chk("ord_rdata",  {23'd0, usr_rvalid, usr_rdata}, {23'd0, 1'b1, 8'h5A});

        // Lock request coincides with forced user grant
        for (int i = 0; i < 8; i++) begin
            @(negedge SysClk);
            spi(1, 1, 12'h200, 8'(i));
            usr(1, 1, 12'h201, 8'(i));
        end
        @(negedge SysClk);
        spi_lock = 1'b1;
        #1;
        chk("coin_force", {29'd0, locked, spi_gnt, usr_gnt}, 32'h1);
        @(negedge SysClk);
        #1;
        chk("coin_lock",  {29'd0, locked, spi_gnt, usr_gnt}, 32'h6);
        @(negedge SysClk);
        spi_lock = 1'b0;
        spi(0, 0, '0, '0);
        usr(0, 0, '0, '0);
        @(negedge SysClk);
        #1;
        chk("coin_unlk",  locked, 0);

        // Reset while an SPI read is in flight under lock
        @(negedge SysClk);
        spi_lock = 1'b1;
        @(negedge SysClk);
        spi(1, 0, 12'hFFF, 8'h00);
        #1;
        chk("mr_acc",     {30'd0, locked, spi_gnt}, 32'h3);
        @(posedge SysClk);
        #1;
        Reset    = 1'b1;
        spi_lock = 1'b0;
        spi(0, 0, '0, '0);
        @(negedge SysClk);
        #1;
        chk("mr_rvalid",  spi_rvalid, 0);
        chk("mr_locked",  locked, 0);
        @(negedge SysClk);
        Reset = 1'b0;
        usr(1, 1, 12'h050, 8'h11);
        #1;
        chk("mr_usr_gnt", usr_gnt, 1);
        chk("mr_spi_rv",  spi_rvalid, 0);
        @(negedge SysClk);
        usr(0, 0, '0, '0);
        repeat (2) @(negedge SysClk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
